// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch sequencer. Issues one instruction-memory read
//            at a time, holds the returned word for the decoder under a
//            valid/ready handshake, and services branch/jump redirects,
//            including redirects that land while a read is still in flight.
// Options  : FETCH_ALIGN_CHECK_EN -- when defined, a misaligned redirect
//            raises a sticky fault_o and halts fetching until reset. When
//            undefined, fault_o is tied low and redirect targets are forced
//            to word alignment.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] program_counter_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            fault_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    // IDLE : not fetching (en low, or halted by a fault)
    // REQ  : read strobe driven for one cycle
    // WAIT : read outstanding, waiting for the ack
    // HOLD : instruction presented to the decoder
    // DRAIN: read outstanding but its data is stale; swallow the ack
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    state_t          resume_state;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_misaligned;
    logic            halted;
    logic            redirect_ok;
    logic            redirect_fault;
    logic            capture;
    logic            transfer;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_latched;

    assign redirect_misaligned = |redirect_pc_i[1:0];
    assign redirect_target     = redirect_pc_i;

    // Sticky fault: set by a misaligned redirect, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fault_latched <= 1'b0;
        end else if (redirect_fault) begin
            fault_latched <= 1'b1;
        end
    end

    assign halted  = fault_latched;
    assign fault_o = fault_latched;
`else
    logic unused_redirect_low;

    // The low address bits are discarded: targets are always word-aligned.
    assign unused_redirect_low = ^redirect_pc_i[1:0];
    assign redirect_misaligned = 1'b0;
    assign redirect_target     = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign halted              = 1'b0;
    assign fault_o             = 1'b0;
`endif

    // A halted sequencer ignores further redirects entirely.
    assign redirect_ok    = redirect_i && !redirect_misaligned && !halted;
    assign redirect_fault = redirect_i &&  redirect_misaligned && !halted;

    // Data returned in WAIT is kept only if no redirect lands in that cycle.
    assign capture  = (state == ST_WAIT) && imem_ack_i && !redirect_i;

    // A redirect beats a simultaneous ready, so that cycle is not a transfer.
    assign transfer = (state == ST_HOLD) && instr_valid_o && instr_ready_i && !redirect_i;

    // Where the FSM goes once the current fetch is finished or abandoned.
    assign resume_state = en ? ST_REQ : ST_IDLE;

    // A redirect in REQ cancels the read strobe so the stale address never
    // reaches memory and at most one read is ever outstanding.
    assign imem_req_o  = (state == ST_REQ) && !redirect_i;
    assign imem_addr_o = imem_req_o ? pc : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        if (halted || redirect_fault) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) begin
                        state_next = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (redirect_i) begin
                        state_next = resume_state;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_i) begin
                        // An ack in the same cycle retires the read, so
                        // there is nothing left to drain.
                        state_next = imem_ack_i ? resume_state : ST_DRAIN;
                    end else if (imem_ack_i) begin
                        state_next = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect_i || instr_ready_i) begin
                        state_next = resume_state;
                    end
                end
                ST_DRAIN: begin
                    // A redirect alone only moves the pc; the ack still
                    // closes out the stale read.
                    if (imem_ack_i) begin
                        state_next = resume_state;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch pc and the decoder-facing instruction register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= RESET_PC;
            instr_valid_o     <= 1'b0;
            instruction_o     <= '0;
            program_counter_o <= '0;
        end else begin
            if (redirect_ok) begin
                pc <= redirect_target;
            end else if (capture) begin
                pc <= pc + PC_STEP;
            end

            if (capture) begin
                instr_valid_o     <= 1'b1;
                instruction_o     <= imem_rdata_i;
                program_counter_o <= pc;
            end else if (transfer || redirect_i) begin
                instr_valid_o     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. A small memory model
//            answers reads after a chosen latency; directed scenarios and a
//            randomized run are checked against the expected program stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instruction_o;
    logic [31:0] program_counter_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        fault_o;

    int total = 0;
    int bad   = 0;

    // memory model state
    bit          pend;
    int          pend_cnt;
    logic [31:0] pend_data;
    int          mem_lat;
    bit          poison_next;
    logic [31:0] poison_val;
    int          overlap_cnt = 0;

    // values sampled mid-cycle by step()
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_instr;
    logic [31:0] s_pc;
    logic        s_fault;
    logic        s_xfer;

    fetch_sequencer #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .en                (en),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_ack_i        (imem_ack_i),
        .imem_rdata_i      (imem_rdata_i),
        .instr_valid_o     (instr_valid_o),
        .instruction_o     (instruction_o),
        .program_counter_o (program_counter_o),
        .instr_ready_i     (instr_ready_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .fault_o           (fault_o)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // One clock cycle: drive ack, sample outputs mid-cycle, then clock edge.
    task automatic step();
        imem_ack_i   = 1'b0;
        imem_rdata_i = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_ack_i   = 1'b1;
                imem_rdata_i = pend_data;
                pend         = 1'b0;
            end
        end
        #1;
        s_req   = imem_req_o;
        s_addr  = imem_addr_o;
        s_valid = instr_valid_o;
        s_instr = instruction_o;
        s_pc    = program_counter_o;
        s_fault = fault_o;
        s_xfer  = instr_valid_o && instr_ready_i && !redirect_i;
        if (imem_req_o && !reset) begin
            if (pend) overlap_cnt++;
            pend      = 1'b1;
            pend_cnt  = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 4));
            pend_data = poison_next ? poison_val : word_at(imem_addr_o);
            poison_next = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit keep_pend);
        reset         = 1'b1;
        en            = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        poison_next   = 1'b0;
        if (!keep_pend) pend = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        total++; if (s_req !== 1'b0)        begin bad++; $display("FAIL reset_req: got %b want 0", s_req); end
        total++; if (s_addr !== 32'h0)      begin bad++; $display("FAIL reset_addr: got %h want 0", s_addr); end
        total++; if (s_valid !== 1'b0)      begin bad++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        total++; if (s_instr !== 32'h0)     begin bad++; $display("FAIL reset_instr: got %h want 0", s_instr); end
        total++; if (s_pc !== 32'h0)        begin bad++; $display("FAIL reset_pc: got %h want 0", s_pc); end
        total++; if (s_fault !== 1'b0)      begin bad++; $display("FAIL reset_fault: got %b want 0", s_fault); end
        begin
            int reqs = 0;
            for (int i = 0; i < 5; i++) begin
                step();
                if (s_req) reqs++;
            end
            total++; if (reqs != 0) begin bad++; $display("FAIL idle_no_req: got %0d requests want 0", reqs); end
        end
    endtask

    task automatic test_sequential();
        logic [31:0] raddr[$];
        logic [31:0] xpc[$];
        logic [31:0] xins[$];
        do_reset(1'b0);
        mem_lat = 2;
        en = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 40 && xpc.size() < 3; i++) begin
            step();
            if (s_req)  raddr.push_back(s_addr);
            if (s_xfer) begin xpc.push_back(s_pc); xins.push_back(s_instr); end
        end
        total++;
        if (xpc.size() < 3 || raddr.size() < 3) begin
            bad++; $display("FAIL seq_timeout: got %0d transfers want 3", xpc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] exp_a;
                exp_a = RST_PC + 32'(4 * i);
                total++; if (raddr[i] !== exp_a) begin bad++; $display("FAIL seq_req_addr%0d: got %h want %h", i, raddr[i], exp_a); end
                total++; if (xpc[i] !== exp_a)   begin bad++; $display("FAIL seq_pc%0d: got %h want %h", i, xpc[i], exp_a); end
                total++; if (xins[i] !== word_at(exp_a)) begin bad++; $display("FAIL seq_instr%0d: got %h want %h", i, xins[i], word_at(exp_a)); end
            end
        end
    endtask

    task automatic test_throughput();
        int rcyc[$];
        do_reset(1'b0);
        mem_lat = 1;
        en = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 30 && rcyc.size() < 4; i++) begin
            step();
            if (s_req) rcyc.push_back(i);
        end
        total++;
        if (rcyc.size() < 4) begin
            bad++; $display("FAIL tput_timeout: got %0d requests want 4", rcyc.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (rcyc[i] - rcyc[i-1] != 3) begin bad++; $display("FAIL tput_gap%0d: got %0d cycles want 3", i, rcyc[i] - rcyc[i-1]); end
            end
        end
    endtask

    task automatic test_hold_stall();
        bit          found = 1'b0;
        logic [31:0] held;
        int          viol = 0;
        do_reset(1'b0);
        mem_lat = 1;
        en = 1'b1;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL stall_timeout: got valid=0 want 1"); end
        held = s_instr;
        total++; if (s_pc !== RST_PC) begin bad++; $display("FAIL stall_pc: got %h want %h", s_pc, RST_PC); end
        total++; if (held !== word_at(RST_PC)) begin bad++; $display("FAIL stall_instr: got %h want %h", held, word_at(RST_PC)); end
        for (int i = 0; i < 5; i++) begin
            step();
            if (!s_valid || s_instr !== held || s_req) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL stall_stable: got %0d bad cycles want 0", viol); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        step();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL stall_valid_drop: got %b want 0", s_valid); end
        total++; if (s_req !== 1'b1 || s_addr !== RST_PC + 32'd4) begin
            bad++; $display("FAIL stall_next_req: got req=%b addr=%h want req=1 addr=%h", s_req, s_addr, RST_PC + 32'd4);
        end
    endtask

    task automatic test_redirect_wait();
        bit          found = 1'b0;
        bit          seen_poison = 1'b0;
        bit          got_req = 1'b0;
        bit          got_x = 1'b0;
        logic [31:0] first_addr = 32'h0;
        logic [31:0] x_pc = 32'h0;
        logic [31:0] x_ins = 32'h0;
        do_reset(1'b0);
        mem_lat = 4;
        poison_val = 32'hDEAD_BEEF;
        poison_next = 1'b1;
        en = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_req) found = 1'b1;
        end
        total++; if (!found || s_addr !== RST_PC) begin bad++; $display("FAIL rw_first_req: got req=%b addr=%h want req=1 addr=%h", found, s_addr, RST_PC); end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        step();
        redirect_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_valid && s_instr === 32'hDEAD_BEEF) seen_poison = 1'b1;
            if (s_req && !got_req) begin got_req = 1'b1; first_addr = s_addr; end
            if (s_xfer && !got_x) begin got_x = 1'b1; x_pc = s_pc; x_ins = s_instr; end
        end
        total++; if (seen_poison) begin bad++; $display("FAIL rw_stale_shown: got DEADBEEF presented want never"); end
        total++; if (!got_req || first_addr !== 32'h200) begin bad++; $display("FAIL rw_next_req: got req=%b addr=%h want addr=00000200", got_req, first_addr); end
        total++; if (!got_x || x_pc !== 32'h200 || x_ins !== word_at(32'h200)) begin
            bad++; $display("FAIL rw_first_xfer: got pc=%h instr=%h want pc=00000200 instr=%h", x_pc, x_ins, word_at(32'h200));
        end
    endtask

    task automatic test_redirect_hold();
        bit found = 1'b0;
        bit got_x = 1'b0;
        do_reset(1'b0);
        mem_lat = 1;
        en = 1'b1;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL rh_timeout: got valid=0 want 1"); end
        instr_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0040;
        step();
        redirect_i = 1'b0;
        instr_ready_i = 1'b0;
        step();
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL rh_valid_drop: got %b want 0", s_valid); end
        total++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin bad++; $display("FAIL rh_next_req: got req=%b addr=%h want req=1 addr=00000040", s_req, s_addr); end
        instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && !got_x; i++) begin
            step();
            if (s_xfer) got_x = 1'b1;
        end
        total++; if (!got_x || s_pc !== 32'h40) begin bad++; $display("FAIL rh_first_xfer: got xfer=%b pc=%h want pc=00000040", got_x, s_pc); end
    endtask

    task automatic test_wrap();
        bit got_x = 1'b0;
        bit got_r = 1'b0;
        do_reset(1'b0);
        mem_lat = 1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        en = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && !got_x; i++) begin
            step();
            if (s_xfer) got_x = 1'b1;
        end
        total++; if (!got_x || s_pc !== 32'hFFFF_FFFC || s_instr !== word_at(32'hFFFF_FFFC)) begin
            bad++; $display("FAIL wrap_xfer: got pc=%h instr=%h want pc=fffffffc instr=%h", s_pc, s_instr, word_at(32'hFFFF_FFFC));
        end
        for (int i = 0; i < 10 && !got_r; i++) begin
            step();
            if (s_req) got_r = 1'b1;
        end
        total++; if (!got_r || s_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_req: got req=%b addr=%h want addr=00000000", got_r, s_addr); end
    endtask

    task automatic test_en_low();
        bit found = 1'b0;
        int reqs = 0;
        do_reset(1'b0);
        mem_lat = 3;
        en = 1'b1;
        instr_ready_i = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_req) found = 1'b1;
        end
        en = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_valid) found = 1'b1;
        end
        total++; if (!found || s_pc !== RST_PC) begin bad++; $display("FAIL enlow_complete: got valid=%b pc=%h want valid=1 pc=%h", found, s_pc, RST_PC); end
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_req) reqs++;
        end
        total++; if (reqs != 0) begin bad++; $display("FAIL enlow_stop: got %0d requests want 0", reqs); end
    endtask

    task automatic test_late_ack_reset();
        bit found = 1'b0;
        int viol = 0;
        do_reset(1'b0);
        mem_lat = 4;
        en = 1'b1;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 10 && !found; i++) begin
            step();
            if (s_req) found = 1'b1;
        end
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (s_valid || s_req) viol++;
        end
        total++; if (viol != 0) begin bad++; $display("FAIL late_ack_ignored: got %0d bad cycles want 0", viol); end
        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            step();
            if (s_req) found = 1'b1;
        end
        total++; if (!found || s_addr !== RST_PC) begin bad++; $display("FAIL late_ack_restart: got req=%b addr=%h want addr=%h", found, s_addr, RST_PC); end
    endtask

    task automatic test_misaligned();
        do_reset(1'b0);
        mem_lat = 1;
        en = 1'b1;
        instr_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0202;
        step();
        redirect_i = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        begin
            int reqs = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (s_req) reqs++;
            end
            total++; if (reqs != 0) begin bad++; $display("FAIL mis_halt: got %0d requests want 0", reqs); end
            total++; if (s_fault !== 1'b1) begin bad++; $display("FAIL mis_fault: got %b want 1", s_fault); end
            total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL mis_valid: got %b want 0", s_valid); end
        end
`else
        begin
            bit found = 1'b0;
            for (int i = 0; i < 5 && !found; i++) begin
                step();
                if (s_req) found = 1'b1;
            end
            total++; if (!found || s_addr !== 32'h200) begin bad++; $display("FAIL mis_align: got req=%b addr=%h want addr=00000200", found, s_addr); end
            total++; if (s_fault !== 1'b0) begin bad++; $display("FAIL mis_fault: got %b want 0", s_fault); end
        end
`endif
    endtask

    // Random traffic checked against the expected program stream: every
    // request and every delivered instruction must be at the next pc of the
    // stream, which advances by 4 per delivery and jumps on each redirect.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] tgt;
        int          xfers = 0;
        do_reset(1'b0);
        mem_lat = 0;
        exp_next = RST_PC;
        for (int c = 0; c < 3000; c++) begin
            en            = ($urandom_range(0, 9) != 0);
            instr_ready_i = ($urandom_range(0, 9) < 6);
            redirect_i    = ($urandom_range(0, 24) == 0);
            tgt           = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            tgt[1:0]      = 2'b00;
`endif
            redirect_pc_i = tgt;
            step();
            if (s_req) begin
                total++;
                if (s_addr !== exp_next) begin bad++; $display("FAIL rand_req_addr: cycle %0d got %h want %h", c, s_addr, exp_next); end
            end
            if (s_xfer) begin
                total++;
                if (s_pc !== exp_next) begin bad++; $display("FAIL rand_xfer_pc: cycle %0d got %h want %h", c, s_pc, exp_next); end
                total++;
                if (s_instr !== word_at(exp_next)) begin bad++; $display("FAIL rand_xfer_instr: cycle %0d got %h want %h", c, s_instr, word_at(exp_next)); end
                exp_next = exp_next + 32'd4;
                xfers++;
            end
            if (redirect_i) exp_next = {tgt[31:2], 2'b00};
        end
        redirect_i = 1'b0;
        total++; if (xfers < 100) begin bad++; $display("FAIL rand_progress: got %0d transfers want >=100", xfers); end
        total++; if (overlap_cnt != 0) begin bad++; $display("FAIL one_outstanding: got %0d overlapping requests want 0", overlap_cnt); end
    endtask

    initial begin
        reset         = 1'b1;
        en            = 1'b0;
        imem_ack_i    = 1'b0;
        imem_rdata_i  = 32'h0;
        instr_ready_i = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        pend          = 1'b0;
        pend_cnt      = 0;
        pend_data     = 32'h0;
        mem_lat       = 1;
        poison_next   = 1'b0;
        poison_val    = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_throughput();
        test_hold_stall();
        test_redirect_wait();
        test_redirect_hold();
        test_wrap();
        test_en_low();
        test_late_ack_reset();
        test_misaligned();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
